// File: rtl/dma_read_sequencer.sv
// Chunked DMA read sequencer: walks cfg_chunk_cnt chunks of cfg_chunk_len bytes
// starting at cfg_base_addr, stepping by cfg_stride, one DMA request at a time.
module dma_read_sequencer #(
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 26,
  parameter int CNT_W       = 16,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [LEN_W-1:0]  cfg_chunk_len,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic [CNT_W-1:0]  cfg_chunk_cnt,
  input  logic              dma_idle,
  input  logic              dma_irq,
  output logic              dma_read_valid,
  output logic [ADDR_W-1:0] dma_sa_config,
  output logic [LEN_W-1:0]  dma_length_config,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  chunks_done
);

  localparam int TMO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_IDLE, ISSUE, WAIT_IRQ, NEXT, ERR
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] stride_q;
  logic [LEN_W-1:0]  len_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  chunks_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              irq_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      chunks_q <= '0;
      tmo_q    <= '0;
      irq_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      // irq history is kept in every state so a level that was already high
      // before the request went out never looks like a fresh completion
      irq_q   <= dma_irq;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      case (state_q)
        IDLE, ERR: begin
          if (start && !abort) begin
            addr_q   <= cfg_base_addr;
            stride_q <= cfg_stride;
            len_q    <= cfg_chunk_len;
            cnt_q    <= cfg_chunk_cnt;
            chunks_q <= '0;
            error_q  <= 1'b0;
            if (cfg_chunk_cnt == '0) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else if (cfg_chunk_len == '0) begin
              state_q <= ERR;
              error_q <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= WAIT_IDLE;
              busy_q  <= 1'b1;
            end
          end
        end
        default: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            case (state_q)
              WAIT_IDLE: begin
                if (dma_idle) begin
                  state_q <= ISSUE;
                  valid_q <= 1'b1;
                end
              end
              ISSUE: begin
                state_q <= WAIT_IRQ;
                tmo_q   <= '0;
              end
              WAIT_IRQ: begin
                if (dma_irq && !irq_q) begin
                  state_q <= NEXT;
                end else if (tmo_q == TMO_LAST) begin
                  state_q <= ERR;
                  error_q <= 1'b1;
                  busy_q  <= 1'b0;
                end else begin
                  tmo_q <= tmo_q + TMO_W'(1);
                end
              end
              NEXT: begin
                chunks_q <= chunks_q + CNT_W'(1);
                addr_q   <= addr_q + stride_q;
                if ((chunks_q + CNT_W'(1)) == cnt_q) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                end else begin
                  state_q <= WAIT_IDLE;
                end
              end
              default: begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign dma_read_valid    = valid_q;
  assign dma_sa_config     = addr_q;
  assign dma_length_config = len_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign error             = error_q;
  assign chunks_done       = chunks_q;

endmodule

// File: tb/tb_dma_read_sequencer.sv
// Bench for dma_read_sequencer: scenario tasks against a closed-form chunk model
// (sa_i = base + i*stride mod 2^32) and a simple DMA engine responder.
module tb_dma_read_sequencer;
  localparam int AW = 32;
  localparam int LW = 26;
  localparam int CW = 16;
  localparam int TMO = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] cfg_base_addr = '0;
  logic [LW-1:0] cfg_chunk_len = '0;
  logic [AW-1:0] cfg_stride = '0;
  logic [CW-1:0] cfg_chunk_cnt = '0;
  logic          dma_idle = 1'b0;
  logic          dma_irq = 1'b0;
  logic          dma_read_valid;
  logic [AW-1:0] dma_sa_config;
  logic [LW-1:0] dma_length_config;
  logic          busy;
  logic          done;
  logic          error;
  logic [CW-1:0] chunks_done;

  dma_read_sequencer #(.ADDR_W(AW), .LEN_W(LW), .CNT_W(CW), .TIMEOUT_CYC(TMO)) dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort),
    .cfg_base_addr(cfg_base_addr), .cfg_chunk_len(cfg_chunk_len),
    .cfg_stride(cfg_stride), .cfg_chunk_cnt(cfg_chunk_cnt),
    .dma_idle(dma_idle), .dma_irq(dma_irq), .dma_read_valid(dma_read_valid),
    .dma_sa_config(dma_sa_config), .dma_length_config(dma_length_config),
    .busy(busy), .done(done), .error(error), .chunks_done(chunks_done)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail = 0;

  logic [AW-1:0] obs_sa[$];
  logic [LW-1:0] obs_len[$];
  bit            obs_busy[$];
  int            first_k, done_cnt, done_k, err_k, abort_k;
  bit            timed_out, busy_after_abort;
  logic [CW-1:0] chunks_after_abort;

  function automatic logic [AW-1:0] model_sa(input logic [AW-1:0] base,
                                             input logic [AW-1:0] stride, input int i);
    return base + AW'(i) * stride;
  endfunction

  // One job with a DMA responder that holds irq high until the next request;
  // delay==0 means the engine never completes.
  task automatic run_job(input logic [AW-1:0] base, input logic [LW-1:0] len,
                         input logic [AW-1:0] stride, input logic [CW-1:0] cnt,
                         input int delay, input int abort_at, input bit restart_mid,
                         input int budget);
    int  cd;
    int  last_vk;
    bit  outstanding;
    obs_sa.delete(); obs_len.delete(); obs_busy.delete();
    first_k = -1; done_cnt = 0; done_k = -1; err_k = -1; abort_k = -1;
    timed_out = 1'b1; busy_after_abort = 1'b1; chunks_after_abort = '1;
    cd = 0; last_vk = -100; outstanding = 1'b0;
    @(negedge CLK);
    cfg_base_addr = base; cfg_chunk_len = len; cfg_stride = stride; cfg_chunk_cnt = cnt;
    dma_idle = 1'b1; dma_irq = 1'b0; start = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge CLK);
      start = 1'b0; abort = 1'b0;
      obs_busy.push_back(busy);
      if (done) begin done_cnt++; if (done_k < 0) done_k = k; end
      if (dma_read_valid) begin
        obs_sa.push_back(dma_sa_config); obs_len.push_back(dma_length_config);
        if (first_k < 0) first_k = k;
        last_vk = k; outstanding = 1'b1; cd = delay; dma_irq = 1'b0;
      end else if (outstanding && delay > 0) begin
        cd--;
        if (cd == 0) begin dma_irq = 1'b1; outstanding = 1'b0; end
      end
      dma_idle = !outstanding;
      if (restart_mid && first_k >= 0 && k == first_k + 1) begin
        start = 1'b1; cfg_base_addr = base ^ 32'h0000_1000;
        cfg_chunk_cnt = cnt + CW'(3); cfg_chunk_len = len + LW'(1);
      end
      if (abort_k >= 0 && k == abort_k + 1) begin
        busy_after_abort = busy; chunks_after_abort = chunks_done;
      end
      if (abort_at > 0 && abort_k < 0 && obs_sa.size() == abort_at && k == last_vk + 2) begin
        abort = 1'b1; abort_k = k;
      end
      if (error && err_k < 0) err_k = k;
      if (done || (error && !busy) || (abort_k >= 0 && k >= abort_k + 10)) begin
        timed_out = 1'b0;
        break;
      end
    end
    start = 1'b0; abort = 1'b0; dma_irq = 1'b0; dma_idle = 1'b1;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    n_checks++;
    if ({dma_read_valid, busy, done, error} !== 4'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b required 0000", {dma_read_valid, busy, done, error});
    end
    RST = 1'b0;
    @(negedge CLK);
    n_checks++;
    if (dma_sa_config !== '0 || dma_length_config !== '0 || chunks_done !== '0) begin
      n_fail++; $display("FAIL reset_regs: got sa=%h len=%h chunks=%0d required zeros",
                         dma_sa_config, dma_length_config, chunks_done);
    end
    n_checks++;
    if ({dma_read_valid, busy, done, error} !== 4'b0) begin
      n_fail++; $display("FAIL reset_release: got %b required 0000", {dma_read_valid, busy, done, error});
    end
    $display("test_reset: outputs checked during and after reset");
  endtask

  task automatic test_basic;
    run_job(32'h0, LW'('h40), 32'h20, CW'(4), 5, 0, 1'b0, 200);
    n_checks++;
    if (timed_out || obs_sa.size() != 4) begin
      n_fail++; $display("FAIL basic_count: got %0d pulses (timeout=%0b) required 4", obs_sa.size(), timed_out);
    end
    for (int i = 0; i < obs_sa.size(); i++) begin
      n_checks++;
      if (obs_sa[i] !== model_sa(32'h0, 32'h20, i) || obs_len[i] !== LW'('h40)) begin
        n_fail++; $display("FAIL basic_chunk%0d: got sa=%h len=%h required sa=%h len=40",
                           i, obs_sa[i], obs_len[i], model_sa(32'h0, 32'h20, i));
      end
      $display("basic chunk %0d sa=%h len=%h", i, obs_sa[i], obs_len[i]);
    end
    n_checks++;
    if (first_k != 2) begin
      n_fail++; $display("FAIL basic_latency: got %0d cycles required 2", first_k);
    end
    n_checks++;
    if (done_cnt != 1 || chunks_done !== CW'(4) || error !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_end: got done=%0d chunks=%0d err=%b busy=%b required 1 4 0 0",
                         done_cnt, chunks_done, error, busy);
    end
  endtask

  task automatic test_wrap;
    run_job(32'hFFFF_FFE0, LW'('h10), 32'h20, CW'(2), 3, 0, 1'b0, 100);
    n_checks++;
    if (obs_sa.size() != 2) begin
      n_fail++; $display("FAIL wrap_count: got %0d required 2", obs_sa.size());
    end else begin
      n_checks++;
      if (obs_sa[0] !== 32'hFFFF_FFE0 || obs_sa[1] !== 32'h0000_0000) begin
        n_fail++; $display("FAIL wrap_sa: got %h %h required ffffffe0 00000000", obs_sa[0], obs_sa[1]);
      end
      $display("wrap sa0=%h sa1=%h done=%0d", obs_sa[0], obs_sa[1], done_cnt);
    end
  endtask

  task automatic test_timeout;
    run_job(32'h100, LW'(8), 32'h4, CW'(1), 0, 0, 1'b0, 100);
    n_checks++;
    if (timed_out || first_k < 0 || obs_busy.size() < first_k + 16) begin
      n_fail++; $display("FAIL timeout_run: got first_k=%0d timeout=%0b required a finished job", first_k, timed_out);
    end else begin
      n_checks++;
      if (obs_busy[first_k + 15] !== 1'b1) begin
        n_fail++; $display("FAIL timeout_early: got busy=0 at 15 cycles into WAIT_IRQ required 1");
      end
      n_checks++;
      if (err_k != first_k + 17) begin
        n_fail++; $display("FAIL timeout_cycle: got error at +%0d required +17 from issue", err_k - first_k);
      end
    end
    n_checks++;
    if (error !== 1'b1 || busy !== 1'b0 || done_cnt != 0) begin
      n_fail++; $display("FAIL timeout_state: got err=%b busy=%b done=%0d required 1 0 0", error, busy, done_cnt);
    end
    $display("timeout error_k=%0d issue_k=%0d", err_k, first_k);
  endtask

  task automatic test_abort;
    run_job(32'h2000, LW'('h80), 32'h100, CW'(3), 5, 2, 1'b0, 200);
    n_checks++;
    if (abort_k < 0 || busy_after_abort !== 1'b0 || chunks_after_abort !== CW'(1)) begin
      n_fail++; $display("FAIL abort_state: got abort_k=%0d busy=%b chunks=%0d required busy 0 chunks 1",
                         abort_k, busy_after_abort, chunks_after_abort);
    end
    n_checks++;
    if (done_cnt != 0 || error !== 1'b0 || obs_sa.size() != 2) begin
      n_fail++; $display("FAIL abort_side: got done=%0d err=%b pulses=%0d required 0 0 2",
                         done_cnt, error, obs_sa.size());
    end
    run_job(32'h3000, LW'('h10), 32'h10, CW'(2), 4, 0, 1'b0, 200);
    n_checks++;
    if (obs_sa.size() != 2 || done_cnt != 1 || chunks_done !== CW'(2) || obs_sa[1] !== 32'h3010) begin
      n_fail++; $display("FAIL abort_rerun: got pulses=%0d done=%0d chunks=%0d required 2 1 2",
                         obs_sa.size(), done_cnt, chunks_done);
    end
    $display("abort at k=%0d, rerun pulses=%0d done=%0d", abort_k, obs_sa.size(), done_cnt);
  endtask

  task automatic test_edges;
    run_job(32'h0, LW'('h10), 32'h4, CW'(0), 3, 0, 1'b0, 10);
    n_checks++;
    if (done_k != 1 || obs_sa.size() != 0) begin
      n_fail++; $display("FAIL cnt0: got done_k=%0d pulses=%0d required 1 0", done_k, obs_sa.size());
    end
    run_job(32'h0, LW'(0), 32'h4, CW'(2), 3, 0, 1'b0, 10);
    n_checks++;
    if (err_k != 1 || error !== 1'b1 || busy !== 1'b0 || obs_sa.size() != 0) begin
      n_fail++; $display("FAIL len0: got err_k=%0d err=%b busy=%b pulses=%0d required 1 1 0 0",
                         err_k, error, busy, obs_sa.size());
    end
    run_job(32'h500, LW'('h20), 32'h40, CW'(3), 4, 0, 1'b1, 200);
    n_checks++;
    if (obs_sa.size() != 3 || done_cnt != 1 || chunks_done !== CW'(3) || error !== 1'b0) begin
      n_fail++; $display("FAIL start_busy_end: got pulses=%0d done=%0d chunks=%0d err=%b required 3 1 3 0",
                         obs_sa.size(), done_cnt, chunks_done, error);
    end
    for (int i = 0; i < obs_sa.size(); i++) begin
      n_checks++;
      if (obs_sa[i] !== model_sa(32'h500, 32'h40, i) || obs_len[i] !== LW'('h20)) begin
        n_fail++; $display("FAIL start_busy_chunk%0d: got sa=%h len=%h required sa=%h len=20",
                           i, obs_sa[i], obs_len[i], model_sa(32'h500, 32'h40, i));
      end
    end
    $display("edges: cnt0 done_k=%0d, len0 err_k=%0d, restart-while-busy pulses=%0d", done_k, err_k, obs_sa.size());
  endtask

  task automatic test_irq_held;
    int  k;
    bit  seen;
    @(negedge CLK);
    cfg_base_addr = 32'h40; cfg_chunk_len = LW'(4); cfg_stride = 32'h4; cfg_chunk_cnt = CW'(1);
    dma_idle = 1'b1; dma_irq = 1'b1; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    seen = 1'b0;
    for (k = 0; k < 20 && !seen; k++) begin
      @(negedge CLK);
      if (dma_read_valid) seen = 1'b1;
    end
    dma_idle = 1'b0;
    repeat (8) @(negedge CLK);
    n_checks++;
    if (!seen || busy !== 1'b1 || chunks_done !== '0 || done !== 1'b0) begin
      n_fail++; $display("FAIL irq_held: got issued=%b busy=%b chunks=%0d required 1 1 0", seen, busy, chunks_done);
    end
    dma_irq = 1'b0;
    @(negedge CLK);
    dma_irq = 1'b1;
    seen = 1'b0;
    for (k = 0; k < 6 && !seen; k++) begin
      @(negedge CLK);
      if (done) seen = 1'b1;
    end
    n_checks++;
    if (!seen || chunks_done !== CW'(1)) begin
      n_fail++; $display("FAIL irq_fresh_edge: got done=%b chunks=%0d required 1 1", seen, chunks_done);
    end
    dma_irq = 1'b0; dma_idle = 1'b1;
    $display("irq_held: level ignored, fresh edge completed chunk");
  endtask

  task automatic test_reset_mid;
    for (int rep = 0; rep < 2; rep++) begin
      int  nv;
      bit  dn;
      @(negedge CLK);
      cfg_base_addr = 32'h8000; cfg_chunk_len = LW'('h30); cfg_stride = 32'h80; cfg_chunk_cnt = CW'(3);
      dma_idle = 1'b1; dma_irq = 1'b0; start = 1'b1;
      nv = 0;
      for (int k = 0; k < 60 && nv < 2; k++) begin
        @(negedge CLK);
        start = 1'b0;
        if (dma_read_valid) begin nv++; dma_irq = 1'b0; end
        else if (nv == 1 && !dma_irq) dma_irq = 1'b1;
      end
      // rep 0 resets in the ISSUE cycle, rep 1 two cycles later in WAIT_IRQ
      repeat (rep * 2) @(negedge CLK);
      RST = 1'b1;
      #1;
      n_checks++;
      if (nv != 2 || {dma_read_valid, busy, done, error} !== 4'b0 || chunks_done !== '0 ||
          dma_sa_config !== '0 || dma_length_config !== '0) begin
        n_fail++; $display("FAIL reset_mid%0d: got nv=%0d v=%b busy=%b chunks=%0d sa=%h len=%h required all 0",
                           rep, nv, dma_read_valid, busy, chunks_done, dma_sa_config, dma_length_config);
      end
      @(negedge CLK);
      RST = 1'b0; dma_irq = 1'b1;
      dn = 1'b0;
      repeat (6) begin @(negedge CLK); if (done || busy || dma_read_valid) dn = 1'b1; end
      n_checks++;
      if (dn) begin
        n_fail++; $display("FAIL reset_mid_quiet%0d: got activity after reset required none", rep);
      end
      dma_irq = 1'b0;
      $display("reset_mid rep %0d: outputs cleared", rep);
    end
  endtask

  task automatic test_random;
    for (int j = 0; j < 6; j++) begin
      logic [AW-1:0] base, stride;
      logic [LW-1:0] len;
      logic [CW-1:0] cnt;
      int            dly;
      base = $urandom; stride = $urandom;
      len = LW'($urandom_range(1, (1 << LW) - 1));
      cnt = CW'($urandom_range(1, 5));
      dly = $urandom_range(2, 9);
      run_job(base, len, stride, cnt, dly, 0, 1'b0, 300);
      n_checks++;
      if (timed_out || obs_sa.size() != int'(cnt) || done_cnt != 1 || chunks_done !== cnt || error !== 1'b0) begin
        n_fail++; $display("FAIL rand%0d_end: got pulses=%0d done=%0d chunks=%0d err=%b required %0d 1 %0d 0",
                           j, obs_sa.size(), done_cnt, chunks_done, error, cnt, cnt);
      end
      for (int i = 0; i < obs_sa.size(); i++) begin
        n_checks++;
        if (obs_sa[i] !== model_sa(base, stride, i) || obs_len[i] !== len) begin
          n_fail++; $display("FAIL rand%0d_chunk%0d: got sa=%h len=%h required sa=%h len=%h",
                             j, i, obs_sa[i], obs_len[i], model_sa(base, stride, i), len);
        end
      end
      $display("random job %0d base=%h stride=%h len=%h cnt=%0d delay=%0d pulses=%0d",
               j, base, stride, len, cnt, dly, obs_sa.size());
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_timeout;
    test_abort;
    test_edges;
    test_irq_held;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_read_sequencer.md
DMA_READ_SEQUENCER -- requirements
Module: dma_read_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the DMA source-address width.
REQ-002 The block SHALL have parameter LEN_W, default 26, meaning the DMA length-field width.
REQ-003 The block SHALL have parameter CNT_W, default 16, meaning the chunk-counter width.
REQ-004 The block SHALL have parameter TIMEOUT_CYC, default 65535, meaning the maximum cycles to wait for dma_irq after an issue.
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-006 The block SHALL have port CLK  in  1  system clock, all logic on the rising edge.
REQ-007 The block SHALL have port RST  in  1  asynchronous, active-high reset.
REQ-008 The block SHALL have port start  in  1  one-cycle request to begin a job.
REQ-009 The block SHALL have port abort  in  1  one-cycle request to cancel the job.
REQ-010 The block SHALL have port cfg_base_addr  in  ADDR_W  first chunk source address.
REQ-011 The block SHALL have port cfg_chunk_len  in  LEN_W  bytes per chunk.
REQ-012 The block SHALL have port cfg_stride  in  ADDR_W  address increment between chunks.
REQ-013 The block SHALL have port cfg_chunk_cnt  in  CNT_W  number of chunks.
REQ-014 The block SHALL have port dma_idle  in  1  DMA read engine ready for a new transfer.
REQ-015 The block SHALL have port dma_irq  in  1  DMA read engine completion, level.
REQ-016 The block SHALL have port dma_read_valid  out  1  one-cycle transfer request to the DMA engine.
REQ-017 The block SHALL have port dma_sa_config  out  ADDR_W  current chunk source address.
REQ-018 The block SHALL have port dma_length_config  out  LEN_W  current chunk length.
REQ-019 The block SHALL have ports busy  out  1, done  out  1 (one-cycle pulse), error  out  1 (sticky), and chunks_done  out  CNT_W (completed-chunk count).

Function
REQ-020 The FSM SHALL have states IDLE, WAIT_IDLE, ISSUE, WAIT_IRQ, NEXT, ERR.
REQ-021 In IDLE or ERR, start SHALL latch all cfg_* inputs, clear error and chunks_done, and go to WAIT_IDLE; cfg_chunk_cnt==0 SHALL instead pulse done next cycle and stay IDLE; cfg_chunk_len==0 SHALL go to ERR.
REQ-022 start SHALL be ignored while busy; busy SHALL be 1 in every state except IDLE and ERR.
REQ-023 WAIT_IDLE SHALL go to ISSUE on the first edge with dma_idle==1.
REQ-024 ISSUE SHALL last exactly one cycle with dma_read_valid==1, then go to WAIT_IRQ; dma_read_valid SHALL be 0 in all other states.
REQ-025 dma_sa_config and dma_length_config SHALL be registered and stable from the ISSUE cycle until NEXT.
REQ-026 WAIT_IRQ SHALL advance to NEXT only on a rising edge of dma_irq (registered 0 then 1); a level held high from before ISSUE SHALL NOT complete the chunk.
REQ-027 If WAIT_IRQ has lasted TIMEOUT_CYC cycles without that edge, the FSM SHALL go to ERR, set error, and drop busy.
REQ-028 NEXT SHALL increment chunks_done, add cfg_stride to the address modulo 2^ADDR_W, then go to IDLE with done pulsed if chunks_done equals cfg_chunk_cnt, else to WAIT_IDLE.
REQ-029 abort in any busy state SHALL return the FSM to IDLE next cycle with no done and error unchanged; abort with start in the same cycle SHALL win.
REQ-030 Latency from start to dma_read_valid SHALL be 2 cycles when dma_idle is already 1.

Reset
REQ-031 On RST the FSM SHALL enter IDLE asynchronously, and all outputs and internal registers SHALL be 0.
REQ-032 RST asserted mid-job SHALL drop dma_read_valid immediately, and no done SHALL follow.

Verification
REQ-033 base=0x0, len=0x40, stride=0x20, cnt=4, with a DMA model that raises irq 5 cycles after valid -> four valid pulses at sa 0x00,0x20,0x40,0x60 with len 0x40, then one done pulse, chunks_done=4.
REQ-034 base=0xFFFF_FFE0, stride=0x20, cnt=2 -> sa 0xFFFF_FFE0 then 0x0000_0000.
REQ-035 dma_irq never asserted, with TIMEOUT_CYC=16 -> error=1 and busy=0 exactly 16 cycles after the WAIT_IRQ entry, and no done.
REQ-036 Abort during the second WAIT_IRQ -> IDLE next cycle, chunks_done=1, no done, and a later start runs cleanly.
REQ-037 cnt=0 gives done one cycle after start with no valid; len=0 gives error=1; start while busy changes nothing; dma_irq held high across ISSUE does not complete the chunk.
REQ-038 RST pulsed while in WAIT_IRQ -> all outputs 0, state IDLE.
